// File: rtl/pdm_cic_decim.sv
// Stereo PDM-to-PCM CIC decimator (ORDER stages, ratio 2**DEC_LOG2); optional DC blocker via PCM_DC_BLOCK_EN.
// Latency: pair valid about 2*ORDER+2 clk after the later channel's decimation wrap (+1 with PCM_DC_BLOCK_EN).
// Backpressure: pcm_valid holds until pcm_ready; a newer pair overwrites an unaccepted one and sets sticky overrun.
module pdm_cic_decim #(
    parameter int ORDER    = 4,
    parameter int DEC_LOG2 = 6,
    parameter int OUT_W    = 16,
    parameter int DC_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pdm_l_stream,
    input  logic                    pdm_l_clk,
    input  logic                    pdm_r_stream,
    input  logic                    pdm_r_clk,
    output logic signed [OUT_W-1:0] pcm_l,
    output logic signed [OUT_W-1:0] pcm_r,
    output logic                    pcm_valid,
    input  logic                    pcm_ready,
    output logic                    overrun
);

    localparam int ACC_W = 2 + ORDER * DEC_LOG2;
    localparam int STG_W = (ORDER > 1) ? $clog2(ORDER) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_COMB_L = 3'd1;
    localparam logic [2:0] S_COMB_R = 3'd2;
    localparam logic [2:0] S_OUT    = 3'd3;
`ifdef PCM_DC_BLOCK_EN
    localparam logic [2:0] S_DCB    = 3'd4;
    localparam logic [2:0] S_AFTER_R = S_DCB;
`else
    localparam logic [2:0] S_AFTER_R = S_OUT;
`endif

    typedef logic [ORDER-1:0][ACC_W-1:0] stages_t;

    // Whole integrator chain in one step: each stage sees the freshly updated value of the one before.
    function automatic stages_t integrate(input stages_t s, input logic bit_in);
        stages_t          r;
        logic [ACC_W-1:0] acc;
        acc = bit_in ? ACC_W'(1) : {ACC_W{1'b1}};
        for (int i = 0; i < ORDER; i++) begin
            acc  = s[i] + acc;
            r[i] = acc;
        end
        return r;
    endfunction

    logic                l_cur, l_prev, r_cur, r_prev;
    logic                l_evt, r_evt, l_wrap, r_wrap;
    logic [DEC_LOG2-1:0] cnt_l, cnt_r;
    stages_t             integ_l, integ_r, integ_l_nxt, integ_r_nxt;
    logic [ACC_W-1:0]    snap_l, snap_r;
    logic                pend_l, pend_r;

    logic [2:0]          state;
    logic [STG_W-1:0]    stg;
    logic                last_stg, is_l;
    stages_t             zl, zr;
    logic [ACC_W-1:0]    cx, comb_in, comb_z, comb_y;
    logic signed [OUT_W-1:0] res_l, res_r;
    logic                have_l, have_r;

    assign l_evt       = l_cur & ~l_prev;
    assign r_evt       = r_cur & ~r_prev;
    assign l_wrap      = l_evt && (cnt_l == '1);
    assign r_wrap      = r_evt && (cnt_r == '1);
    assign integ_l_nxt = integrate(integ_l, pdm_l_stream);
    assign integ_r_nxt = integrate(integ_r, pdm_r_stream);

    assign is_l     = (state == S_COMB_L);
    assign last_stg = (stg == STG_W'(ORDER - 1));
    assign comb_in  = (stg == '0) ? (is_l ? snap_l : snap_r) : cx;
    assign comb_z   = is_l ? zl[stg] : zr[stg];
    assign comb_y   = comb_in - comb_z;

    always_ff @(posedge clk) begin
        if (rst) begin
            l_cur   <= 1'b0;
            l_prev  <= 1'b0;
            r_cur   <= 1'b0;
            r_prev  <= 1'b0;
            cnt_l   <= '0;
            cnt_r   <= '0;
            integ_l <= '0;
            integ_r <= '0;
            snap_l  <= '0;
            snap_r  <= '0;
            pend_l  <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            l_cur  <= pdm_l_clk;
            l_prev <= l_cur;
            r_cur  <= pdm_r_clk;
            r_prev <= r_cur;
            if (l_evt) begin
                integ_l <= integ_l_nxt;
                cnt_l   <= cnt_l + 1'b1;
            end
            if (r_evt) begin
                integ_r <= integ_r_nxt;
                cnt_r   <= cnt_r + 1'b1;
            end
            // A fresh wrap wins over the engine clearing the flag: that snapshot is still unprocessed.
            if (l_wrap) begin
                snap_l <= integ_l_nxt[ORDER-1];
                pend_l <= 1'b1;
            end else if (is_l && last_stg) begin
                pend_l <= 1'b0;
            end
            if (r_wrap) begin
                snap_r <= integ_r_nxt[ORDER-1];
                pend_r <= 1'b1;
            end else if (state == S_COMB_R && last_stg) begin
                pend_r <= 1'b0;
            end
        end
    end

`ifdef PCM_DC_BLOCK_EN
    localparam int FW = OUT_W + DC_SHIFT;

    logic signed [FW-1:0]    dcy_l, dcy_r;
    logic signed [OUT_W-1:0] dcx_l, dcx_r;

    // y carries DC_SHIFT fraction bits; clamping y to FW bits keeps its integer part within OUT_W.
    function automatic logic signed [FW-1:0] dcb_next(input logic signed [OUT_W-1:0] x,
                                                      input logic signed [OUT_W-1:0] xp,
                                                      input logic signed [FW-1:0]    y);
        logic signed [FW+1:0] s;
        s = (((FW+2)'(x) - (FW+2)'(xp)) <<< DC_SHIFT) + (FW+2)'(y) - (FW+2)'(y >>> DC_SHIFT);
        if (s[FW+1:FW-1] == 3'b000 || s[FW+1:FW-1] == 3'b111)
            return s[FW-1:0];
        return s[FW+1] ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            stg       <= '0;
            zl        <= '0;
            zr        <= '0;
            cx        <= '0;
            res_l     <= '0;
            res_r     <= '0;
            have_l    <= 1'b0;
            have_r    <= 1'b0;
            pcm_l     <= '0;
            pcm_r     <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef PCM_DC_BLOCK_EN
            dcy_l     <= '0;
            dcy_r     <= '0;
            dcx_l     <= '0;
            dcx_r     <= '0;
`endif
        end else begin
            if (pcm_valid && pcm_ready)
                pcm_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    stg <= '0;
                    if (pend_l)
                        state <= S_COMB_L;
                    else if (pend_r)
                        state <= S_COMB_R;
                    else if (have_l && have_r)
                        state <= S_AFTER_R;
                end
                S_COMB_L, S_COMB_R: begin
                    cx  <= comb_y;
                    stg <= stg + 1'b1;
                    if (is_l)
                        zl[stg] <= comb_in;
                    else
                        zr[stg] <= comb_in;
                    if (last_stg) begin
                        stg <= '0;
                        if (is_l) begin
                            res_l  <= comb_y[ACC_W-1 -: OUT_W];
                            have_l <= 1'b1;
                            state  <= pend_r ? S_COMB_R : S_IDLE;
                        end else begin
                            res_r  <= comb_y[ACC_W-1 -: OUT_W];
                            have_r <= 1'b1;
                            state  <= have_l ? S_AFTER_R : S_IDLE;
                        end
                    end
                end
`ifdef PCM_DC_BLOCK_EN
                S_DCB: begin
                    dcy_l <= dcb_next(res_l, dcx_l, dcy_l);
                    dcy_r <= dcb_next(res_r, dcx_r, dcy_r);
                    dcx_l <= res_l;
                    dcx_r <= res_r;
                    state <= S_OUT;
                end
`endif
                S_OUT: begin
`ifdef PCM_DC_BLOCK_EN
                    pcm_l <= dcy_l[FW-1 -: OUT_W];
                    pcm_r <= dcy_r[FW-1 -: OUT_W];
`else
                    pcm_l <= res_l;
                    pcm_r <= res_r;
`endif
                    pcm_valid <= 1'b1;
                    if (pcm_valid && !pcm_ready)
                        overrun <= 1'b1;
                    have_l <= 1'b0;
                    have_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Directed bench for pdm_cic_decim: steady-state vector table plus backpressure and mid-run reset sequences.
module tb_pdm_cic_decim;

    logic               clk = 1'b0;
    logic               rst;
    logic               pdm_l_stream, pdm_l_clk, pdm_r_stream, pdm_r_clk;
    logic signed [15:0] pcm_l, pcm_r;
    logic               pcm_valid, pcm_ready, overrun;

    always #5 clk = ~clk;

    pdm_cic_decim dut (
        .clk(clk), .rst(rst),
        .pdm_l_stream(pdm_l_stream), .pdm_l_clk(pdm_l_clk),
        .pdm_r_stream(pdm_r_stream), .pdm_r_clk(pdm_r_clk),
        .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready), .overrun(overrun)
    );

    // Pattern modes: 0 all zeros, 1 all ones, 2 alternating starting with 1.
    typedef struct {
        int ml;
        int mr;
        int exp_l;
        int exp_r;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   ph, nl, nr, ml, mr;
    bit   r_seen, gen_en;
    int   got_l[8], got_r[8];
    int   ngot;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic pat_bit(input int m, input int idx);
        if (m == 0) return 1'b0;
        if (m == 1) return 1'b1;
        return (idx % 2) == 0;
    endfunction

    // One clk cycle; side clocks have a 4-clk period, left high in phases 0-1, right in 2-3.
    task automatic step();
        @(posedge clk);
        #1;
        if (gen_en) begin
            ph = (ph + 1) % 4;
            if (ph == 0) begin
                pdm_l_clk = 1'b1;
                pdm_r_clk = 1'b0;
                if (r_seen) begin
                    nr++;
                    pdm_r_stream = pat_bit(mr, nr);
                end
            end else if (ph == 2) begin
                pdm_l_clk = 1'b0;
                pdm_r_clk = 1'b1;
                r_seen = 1'b1;
                nl++;
                pdm_l_stream = pat_bit(ml, nl);
            end
        end else begin
            pdm_l_clk = 1'b0;
            pdm_r_clk = 1'b0;
        end
    endtask

    task automatic start_gen(input int l_mode, input int r_mode);
        ml = l_mode;
        mr = r_mode;
        nl = 0;
        nr = 0;
        r_seen = 1'b0;
        ph = 3;
        pdm_l_stream = pat_bit(ml, 0);
        pdm_r_stream = pat_bit(mr, 0);
        gen_en = 1'b1;
    endtask

    task automatic do_reset();
        gen_en = 1'b0;
        pdm_l_clk = 1'b0;
        pdm_r_clk = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic collect(input int n, input int budget);
        int cyc;
        ngot = 0;
        cyc = 0;
        while (ngot < n && cyc < budget) begin
            step();
            cyc++;
            if (pcm_valid && pcm_ready) begin
                got_l[ngot] = pcm_l;
                got_r[ngot] = pcm_r;
                ngot++;
            end
        end
        check("collect_pairs", ngot, n);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{1, 1,  16384,  16384};
        vecs[1] = '{1, 0,  16384, -16384};
        vecs[2] = '{0, 1, -16384,  16384};
        vecs[3] = '{2, 2,      0,      0};
        vecs[4] = '{0, 0, -16384, -16384};
        vecs[5] = '{2, 1,      0,  16384};

        pdm_l_stream = 1'b0;
        pdm_r_stream = 1'b0;
        pdm_l_clk = 1'b0;
        pdm_r_clk = 1'b0;
        pcm_ready = 1'b1;
        gen_en = 1'b0;
        ph = 3;
        rst = 1'b1;
        do_reset();

        check("reset_pcm_l", pcm_l, 0);
        check("reset_pcm_r", pcm_r, 0);
        check("reset_valid", pcm_valid, 0);
        check("reset_overrun", overrun, 0);

        // Steady-state table: pairs 4..6 must sit at the full-scale / zero levels.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            pcm_ready = 1'b1;
            start_gen(vecs[v].ml, vecs[v].mr);
            collect(7, 7 * 256 + 300);
            for (int p = 4; p < 7; p++) begin
                check($sformatf("vec%0d_pair%0d_l", v, p), got_l[p], vecs[v].exp_l);
                check($sformatf("vec%0d_pair%0d_r", v, p), got_r[p], vecs[v].exp_r);
            end
            check($sformatf("vec%0d_overrun", v), overrun, 0);
        end

        // Backpressure: transient pairs of all-ones input are C(67,4)>>10=748, then 8447, then 15763.
        do_reset();
        pcm_ready = 1'b0;
        start_gen(1, 1);
        cyc = 0;
        while (!pcm_valid && cyc < 400) begin step(); cyc++; end
        check("bp_pair0_valid", pcm_valid, 1);
        check("bp_pair0_l", pcm_l, 748);
        check("bp_pair0_r", pcm_r, 748);
        check("bp_pair0_overrun", overrun, 0);
        cyc = 0;
        while (pcm_l == 748 && cyc < 400) begin step(); cyc++; end
        check("bp_pair1_l", pcm_l, 8447);
        check("bp_pair1_r", pcm_r, 8447);
        check("bp_pair1_valid", pcm_valid, 1);
        check("bp_pair1_overrun", overrun, 1);
        cyc = 0;
        while (pcm_l == 8447 && cyc < 400) begin step(); cyc++; end
        check("bp_pair2_l", pcm_l, 15763);
        check("bp_pair2_valid", pcm_valid, 1);
        pcm_ready = 1'b1;
        step();
        check("bp_valid_drop", pcm_valid, 0);
        check("bp_overrun_sticky", overrun, 1);

        // Mid-run reset with a held pair and overrun set, input still running.
        pcm_ready = 1'b0;
        cyc = 0;
        while (!pcm_valid && cyc < 400) begin step(); cyc++; end
        check("pre_rst_valid", pcm_valid, 1);
        for (int i = 0; i < 50; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_pcm_l", pcm_l, 0);
        check("midrst_pcm_r", pcm_r, 0);
        check("midrst_valid", pcm_valid, 0);
        check("midrst_overrun", overrun, 0);
        pcm_ready = 1'b1;
        cyc = 0;
        while (!pcm_valid && cyc < 600) begin step(); cyc++; end
        check("midrst_first_pair_late", int'(cyc >= 240 && cyc < 600), 1);
        check("midrst_first_l", pcm_l, 748);
        check("midrst_first_r", pcm_r, 748);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
